// File: rtl/echo_effect_pkg.sv
// Shared definitions for the audio effect stages: sample width, clamp limits,
// control state encoding and the 19-to-18-bit saturating helper.
package echo_effect_pkg;

  localparam int SAMPLE_W = 18;
  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 18'sh20000;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD_WAIT,
    MIX,
    WRITE
  } state_t;

  // Overflow shows up as the two top bits of the wide sum disagreeing.
  function automatic logic signed [SAMPLE_W-1:0] sat_sum(input logic signed [SAMPLE_W:0] sum);
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
      return sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end
    return sum[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Single-port delay line storage with synchronous read and write.
// Contents are deliberately not reset; the owner clears them after reset.
module echo_delay_ram #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/echo_effect.sv
// Echo stage: mixes each new sample with a decayed copy of the output DEPTH
// samples earlier, kept in a circular delay RAM; one sample every 4 cycles.
module echo_effect
  import echo_effect_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int ADDR_W      = 12,
  parameter int DECAY_SHIFT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                busy,
  output logic                dropped
);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic signed [SAMPLE_W-1:0] in_q, in_d;
  logic signed [SAMPLE_W-1:0] dly_q, dly_d;
  logic signed [SAMPLE_W-1:0] mix_q, mix_d;
  logic signed [SAMPLE_W-1:0] out_q, out_d;
  logic en_q, en_d;
  logic out_valid_q, out_valid_d;
  logic dropped_q, dropped_d;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [SAMPLE_W-1:0] ram_wdata;
  logic [SAMPLE_W-1:0] ram_rdata;

  logic signed [SAMPLE_W-1:0] dly_shifted;
  logic signed [SAMPLE_W:0]   mix_sum;

  assign dly_shifted = dly_q >>> DECAY_SHIFT;
  assign mix_sum     = {in_q[SAMPLE_W-1], in_q} + {dly_shifted[SAMPLE_W-1], dly_shifted};

  echo_delay_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    in_d        = in_q;
    en_d        = en_q;
    dly_d       = dly_q;
    mix_d       = mix_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    dropped_d   = dropped_q;
    ram_we      = 1'b0;
    ram_addr    = wr_ptr_q;
    ram_wdata   = '0;

    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // The RAM read of wr_ptr is launched by this edge regardless.
        if (sample_valid) begin
          in_d    = sample_in;
          en_d    = enable;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        dly_d     = ram_rdata;
        dropped_d = dropped_q | sample_valid;
        state_d   = MIX;
      end
      MIX: begin
        mix_d     = en_q ? sat_sum(mix_sum) : in_q;
        dropped_d = dropped_q | sample_valid;
        state_d   = WRITE;
      end
      WRITE: begin
        // Bypassed samples write zero so stale echo never replays.
        ram_we      = 1'b1;
        ram_wdata   = en_q ? mix_q : '0;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        out_d       = mix_q;
        out_valid_d = 1'b1;
        dropped_d   = dropped_q | sample_valid;
        state_d     = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      wr_ptr_q    <= '0;
      in_q        <= '0;
      en_q        <= 1'b0;
      dly_q       <= '0;
      mix_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      in_q        <= in_d;
      en_q        <= en_d;
      dly_q       <= dly_d;
      mix_q       <= mix_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      dropped_q   <= dropped_d;
    end
  end

  assign sample_out       = out_q;
  assign sample_out_valid = out_valid_q;
  assign busy             = (state_q != IDLE);
  assign dropped          = dropped_q;

endmodule
